// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 registered round-robin multiplexer.
package mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2 for elaboration-time widths.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Producer/consumer handshake bundle for mux_nto1_rr; the DUT sits on the slave modport.
interface mux_nto1_rr_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int SELW = clog2(NCH);

  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SELW-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping modulo NCH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx
);

  logic            w_found;
  logic [SELW-1:0] w_cand;

  // Search ptr+1, ptr+2, ... ptr+NCH; the last candidate is ptr itself.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = SELW'((int'(ptr) + k) % NCH);
      if (!w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-channel registered multiplexer with static or round-robin selection and a
// one-entry output register that drains and reloads in the same cycle.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 4,
  localparam int SELW  = clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_nto1_rr_if.slave   bus
);

  logic [NCH-1:0]   w_rr_grant;
  logic [SELW-1:0]  w_rr_idx;
  logic [NCH-1:0]   w_static_grant;
  logic [NCH-1:0]   w_grant;
  logic [SELW-1:0]  w_idx;
  logic [NCH-1:0]   w_in_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_load_en;
  logic             w_xfer;

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (bus.in_valid),
    .ptr       (r_ptr),
    .grant     (w_rr_grant),
    .grant_idx (w_rr_idx)
  );

  // Static grant is independent of in_valid; an out-of-range sel grants nothing.
  always_comb begin
    w_static_grant = '0;
    if (int'(bus.sel) < NCH) begin
      w_static_grant[bus.sel] = 1'b1;
    end else begin
      w_static_grant = '0;
    end
  end

  // Mode select and handshake; ready is held low while reset is asserted.
  always_comb begin
    w_load_en = !r_out_valid || bus.out_ready;
    if (bus.mode == MODE_RR) begin
      w_grant = w_rr_grant;
      w_idx   = w_rr_idx;
    end else begin
      w_grant = w_static_grant;
      w_idx   = bus.sel;
    end
    w_in_ready = w_grant & {NCH{w_load_en & rst_n}};
    w_xfer     = |(bus.in_valid & w_in_ready);
  end

  // One-hot data select driven by the active grant.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end else begin
        w_sel_data = w_sel_data;
      end
    end
  end

  // Output register and round-robin pointer; both freeze while the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SELW'(NCH - 1);
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_idx;
        if (bus.mode == MODE_RR) begin
          r_ptr <= w_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

endmodule

// File: doc/mux_nto1_rr.md
# mux_nto1_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes. It replaces the fixed 4-to-1 combinational mux in datapaths where several producers share one consumer. Two selection modes are supported: static (external `sel`) and round-robin arbitration among valid channels. The selected word is captured in a one-entry output register that sustains full throughput under backpressure.

## Interface
- `WIDTH`, 4: data width per channel, ≥1.
- `NCH`, 4: number of input channels, ≥2; power of two not required.
- `SELW`, `$clog2(NCH)`: width of the select and channel-id fields; derived, not overridden.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `mode`  in  1  0 = static select, 1 = round-robin.
- `sel`  in  SELW  channel index used in static mode.
- `in_data`  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NCH  per-channel valid.
- `in_ready`  out  NCH  per-channel ready; one-hot or zero.
- `out_data`  out  WIDTH  registered selected word.
- `out_ch`  out  SELW  index of the channel that produced `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- Load enable: `load_en = !out_valid || out_ready`.
- Static mode:
  - `grant` is one-hot at `sel`.
  - If `sel >= NCH`, `grant = 0`; nothing is accepted.
- Round-robin mode:
  - `grant` is the first `i` with `in_valid[i]=1`, searching from `ptr+1` upward and wrapping modulo `NCH`.
  - If no channel is valid, `grant = 0`.
- `in_ready = grant & {NCH{load_en}}`.
- `in_ready[i]` never depends on `in_valid[i]` in static mode, but depends on all `in_valid` bits in round-robin mode.
- Transfer on channel i: `in_valid[i] && in_ready[i]`.
- On a transfer: `out_data <= in_data[i]`, `out_ch <= i`, `out_valid <= 1`.
- Round-robin mode also updates `ptr <= i` on a transfer.
- On `load_en` with no transfer: `out_valid <= 0`, and `out_data`/`out_ch` hold.
- `ptr` updates only on a round-robin transfer. It does not move in static mode or when the output is stalled.
- `mode` and `sel` are sampled every cycle. Changing them never alters a word already held in the output register.
- A valid channel that is not granted waits; no data is dropped, because a channel's word is consumed only on its own transfer.

## Timing
- Reset (`rst_n=0`, asynchronous): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=NCH-1`, so channel 0 has first round-robin priority.
- While in reset, `in_ready=0`, since `load_en` is irrelevant during reset.
- Latency: a word accepted at edge k appears with `out_valid=1` after edge k.
- Throughput: one word per cycle while `out_ready=1`. Simultaneous drain and load in the same cycle is required.
- Backpressure: `out_valid=1 && out_ready=0` holds `out_data`, `out_ch` and `ptr` stable, and forces `in_ready=0`.
- Reset asserted mid-transfer: the held word is discarded and `ptr` returns to `NCH-1`.
- The first rising edge after `rst_n` deasserts may accept a word.
- Round-robin wrap: with `ptr=NCH-1`, the search starts at channel 0.
- Fairness: with all channels valid continuously, each channel is granted exactly once in every `NCH` consecutive transfers.

## Structure
- Shared package `mux_pkg` holds:
  - `MODE_STATIC = 1'b0`
  - `MODE_RR = 1'b1`
  - a `clog2` helper function, for tools lacking `$clog2`.
- Sub-module `rr_arbiter` (parameter `NCH`) contains:
  - inputs: `req[NCH]`, `ptr`
  - outputs: `grant[NCH]` (one-hot or zero), `grant_idx`
  - purely combinational.
- `mux_nto1_rr` owns `ptr`, the output register, the static/round-robin select and the handshake logic.

## Test plan
- Static, NCH=4, WIDTH=4:
  - stimulus: a,b,c,d = 0000, 0101, 1010, 1111, all valid, `out_ready=1`; `sel` steps 0→1→2→3 every 2 cycles.
  - response: `out_data` follows one cycle behind `sel`; `out_ch` equals the previous `sel`; `in_ready` is one-hot on `sel`.
- Round-robin, all valid, `out_ready=1`:
  - response: after reset, `out_ch` sequence is 0,1,2,3,0,1; the data sequence is 0000, 0101, 1010, 1111 repeating.
- Round-robin, sparse valid:
  - stimulus: only channels 1 and 3 valid.
  - response: `out_ch` alternates 1,3,1,3; channels 0 and 2 see `in_ready=0`.
- Backpressure:
  - stimulus: `out_ready=0` for 3 cycles while holding `out_data=0101`.
  - response: output stable, `in_ready=0`, `ptr` frozen.
  - then: on release, the next grant is channel 2.
- Reset mid-stream:
  - stimulus: `rst_n` pulled low asynchronously between edges.
  - response: `out_valid` drops immediately, `out_data=0000`.
  - then: after release, the first round-robin grant is channel 0.
- Out-of-range select:
  - stimulus: NCH=3, static mode, `sel=3`.
  - response: `in_ready=000`; `out_valid` falls to 0 after drain.
